// File: rtl/rom_stream_reader.sv
// Reads a contiguous, wrapping ROM address range and streams the returned bytes
// over valid/ready, absorbing the ROM's one-cycle registered read latency.
module rom_stream_reader #(
    parameter int ROM_ADDR_WIDTH = 8,
    parameter int ROM_DATA_WIDTH = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      in_clk,
    input  logic                      in_rst_n,
    input  logic                      in_start,
    input  logic [ROM_ADDR_WIDTH-1:0] in_base_addr,
    input  logic [ROM_ADDR_WIDTH:0]   in_length,
    input  logic                      in_abort,
    output logic [ROM_ADDR_WIDTH-1:0] out_rom_addr,
    input  logic [ROM_DATA_WIDTH-1:0] in_rom_data,
    output logic [ROM_DATA_WIDTH-1:0] out_data,
    output logic                      out_valid,
    output logic                      out_last,
    input  logic                      in_ready,
    output logic                      out_busy,
    output logic                      out_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LEN_W = ROM_ADDR_WIDTH + 1;
    localparam logic [CNT_W:0]          DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [LEN_W-1:0]        LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [ROM_ADDR_WIDTH-1:0] ADDR_ONE = {{(ROM_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]        PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_next_s;
    logic [ROM_ADDR_WIDTH-1:0] next_addr_r;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr_r;
    logic [LEN_W-1:0]          issue_left_r;
    logic [LEN_W-1:0]          pop_left_r;
    logic                      rd1_r;
    logic                      rd2_r;
    logic [ROM_DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_r;
    logic [PTR_W-1:0]          rd_ptr_r;
    logic [CNT_W-1:0]          count_r;
    logic                      busy_r;
    logic                      done_r;

    logic                      active_s;
    logic                      valid_s;
    logic                      pop_s;
    logic                      push_s;
    logic                      last_s;
    logic                      issue_s;
    logic                      start_s;
    logic                      abort_s;
    logic                      complete_s;
    logic [CNT_W:0]            occ_s;

    // Handshake, credit and command decode from registered state
    always_comb begin
        active_s   = (state_r != IDLE);
        valid_s    = active_s && (count_r != '0);
        pop_s      = valid_s && in_ready;
        push_s     = rd2_r;
        last_s     = valid_s && (pop_left_r == LEN_ONE);
        complete_s = pop_s && last_s;
        start_s    = (state_r == IDLE) && in_start && !in_abort;
        abort_s    = active_s && in_abort;
        // Credit counts both FIFO entries and reads still in the ROM pipeline
        occ_s      = {1'b0, count_r} + {{CNT_W{1'b0}}, rd1_r} + {{CNT_W{1'b0}}, rd2_r};
        issue_s    = (state_r == RUN) && (issue_left_r != '0) && (occ_s < DEPTH_C);
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s && (in_length != '0)) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (abort_s) begin
                    state_next_s = IDLE;
                end else if (issue_s && (issue_left_r == LEN_ONE)) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                if (abort_s || complete_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Address issue, read pipeline, FIFO and status datapath
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            next_addr_r  <= '0;
            rom_addr_r   <= '0;
            issue_left_r <= '0;
            pop_left_r   <= '0;
            rd1_r        <= 1'b0;
            rd2_r        <= 1'b0;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            if (abort_s) begin
                // Clearing the pipeline flags drops any ROM return still on its way
                rd1_r    <= 1'b0;
                rd2_r    <= 1'b0;
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                count_r  <= '0;
                busy_r   <= 1'b0;
            end else begin
                if (start_s) begin
                    next_addr_r  <= in_base_addr;
                    issue_left_r <= in_length;
                    pop_left_r   <= in_length;
                    busy_r       <= (in_length != '0);
                    done_r       <= (in_length == '0);
                end
                if (issue_s) begin
                    rom_addr_r   <= next_addr_r;
                    next_addr_r  <= next_addr_r + ADDR_ONE;
                    issue_left_r <= issue_left_r - LEN_ONE;
                end
                rd1_r <= issue_s;
                rd2_r <= rd1_r;
                if (push_s) begin
                    mem_r[wr_ptr_r] <= in_rom_data;
                    wr_ptr_r        <= wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                    pop_left_r <= pop_left_r - LEN_ONE;
                end
                count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
                if (complete_s) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign out_rom_addr = rom_addr_r;
    assign out_valid    = valid_s;
    assign out_last     = last_s;
    assign out_data     = valid_s ? mem_r[rd_ptr_r] : '0;
    assign out_busy     = busy_r;
    assign out_done     = done_r;

endmodule
